// File: rtl/subpel_window_streamer.sv
// subpel_window_streamer
//   Streams a run of WIN-pixel row (or column) vectors from one of NUM_PLANES
//   WINxWIN pixel planes (integer, a/b/c half-pel) to a downstream FIR stage,
//   using a valid/ready handshake. Each accepted beat moves to the next
//   row/column, wrapping from WIN-1 back to 0.
//
//   Optional feature macro: WINDOW_COLUMN_MODE_EN
//     defined   : the mode input selects row (0) or column (1) vectors
//     undefined : mode is ignored, row vectors only, no column mux is built
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   start      command strobe, accepted only while busy=0
//   plane_sel  plane for the command (out of range -> plane 0)
//   mode       0=row vectors, 1=column vectors
//   start_idx  first row/column index (out of range -> 0)
//   count      number of vectors to emit (0..WIN)
//   plane_bus  pixel (p,r,c) at bit ((p*WIN+r)*WIN+c)*PIX_W, held stable while busy
//   busy       command in progress
//   out_valid  out_data valid
//   out_ready  downstream accepts when out_valid & out_ready
//   out_data   pixel k at bits [k*PIX_W +: PIX_W]
//   out_index  row/column index of the presented vector
//   out_last   presented vector is the final one of the command
//   done       one-cycle pulse at command completion
module subpel_window_streamer #(
    parameter int PIX_W      = 8,
    parameter int WIN        = 15,
    parameter int NUM_PLANES = 4,
    localparam int IDX_W     = $clog2(WIN),
    localparam int PSEL_W    = $clog2(NUM_PLANES),
    localparam int CNT_W     = IDX_W + 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [PSEL_W-1:0]                 plane_sel,
    input  logic                              mode,
    input  logic [IDX_W-1:0]                  start_idx,
    input  logic [CNT_W-1:0]                  count,
    input  logic [NUM_PLANES*WIN*WIN*PIX_W-1:0] plane_bus,
    output logic                              busy,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIN*PIX_W-1:0]              out_data,
    output logic [IDX_W-1:0]                  out_index,
    output logic                              out_last,
    output logic                              done
);

    typedef enum logic [0:0] {StIdle, StStream} state_t;

    state_t              state;
    logic [PSEL_W-1:0]   plane_q;
    logic [CNT_W-1:0]    remaining;

    logic [PSEL_W-1:0]   start_plane;
    logic [IDX_W-1:0]    start_index;
    logic [IDX_W-1:0]    next_index;
    logic [PSEL_W-1:0]   sel_plane;
    logic [IDX_W-1:0]    sel_index;
    logic [WIN*PIX_W-1:0] vec;

`ifdef WINDOW_COLUMN_MODE_EN
    logic                mode_q;
    logic                sel_mode;
`else
    logic                unused_mode;
    assign unused_mode = mode;
`endif

    // One vector mux shared by the first beat (fed from the command inputs)
    // and every following beat (fed from the latched command and next index).
    always_comb begin
        start_plane = (int'(plane_sel) >= NUM_PLANES) ? '0 : plane_sel;
        start_index = (int'(start_idx) >= WIN) ? '0 : start_idx;
        next_index  = (out_index == IDX_W'(WIN - 1)) ? '0 : out_index + 1'b1;
        if (state == StIdle) begin
            sel_plane = start_plane;
            sel_index = start_index;
        end else begin
            sel_plane = plane_q;
            sel_index = next_index;
        end
`ifdef WINDOW_COLUMN_MODE_EN
        sel_mode = (state == StIdle) ? mode : mode_q;
`endif
        vec = '0;
        for (int k = 0; k < WIN; k++) begin
            vec[k*PIX_W +: PIX_W] =
                plane_bus[((int'(sel_plane) * WIN + int'(sel_index)) * WIN + k) * PIX_W +: PIX_W];
`ifdef WINDOW_COLUMN_MODE_EN
            if (sel_mode) begin
                vec[k*PIX_W +: PIX_W] =
                    plane_bus[((int'(sel_plane) * WIN + k) * WIN + int'(sel_index)) * PIX_W +: PIX_W];
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= StIdle;
            plane_q   <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
`ifdef WINDOW_COLUMN_MODE_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            plane_q   <= start_plane;
                            out_index <= start_index;
                            remaining <= count;
                            out_data  <= vec;
                            out_valid <= 1'b1;
                            out_last  <= (count == CNT_W'(1));
                            busy      <= 1'b1;
                            state     <= StStream;
`ifdef WINDOW_COLUMN_MODE_EN
                            mode_q    <= mode;
`endif
                        end
                    end
                end
                StStream: begin
                    // out_valid is always high here, so out_ready alone means a beat left.
                    if (out_ready) begin
                        if (remaining == CNT_W'(1)) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= StIdle;
                        end else begin
                            out_index <= next_index;
                            remaining <= remaining - 1'b1;
                            out_data  <= vec;
                            out_last  <= (remaining == CNT_W'(2));
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_subpel_window_streamer.sv
// tb_subpel_window_streamer
//   Directed bench for subpel_window_streamer (WIN=15, PIX_W=8, 4 planes).
//   Plane p pixel(r,c) = {p[1:0],r[3:0]} ^ c. Commands push their expected
//   beats into a queue; a monitor compares every presented vector against the
//   queue head and pops on acceptance, and times each done pulse.
module tb_subpel_window_streamer;

    localparam int PIX_W  = 8;
    localparam int WIN    = 15;
    localparam int NP     = 4;
    localparam int IDX_W  = 4;
    localparam int PSEL_W = 2;
    localparam int CNT_W  = 5;

    logic                        clock;
    logic                        reset;
    logic                        start;
    logic [PSEL_W-1:0]           plane_sel;
    logic                        mode;
    logic [IDX_W-1:0]            start_idx;
    logic [CNT_W-1:0]            count;
    logic [NP*WIN*WIN*PIX_W-1:0] plane_bus;
    logic                        busy;
    logic                        out_valid;
    logic                        out_ready;
    logic [WIN*PIX_W-1:0]        out_data;
    logic [IDX_W-1:0]            out_index;
    logic                        out_last;
    logic                        done;

    subpel_window_streamer #(
        .PIX_W      (PIX_W),
        .WIN        (WIN),
        .NUM_PLANES (NP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .plane_sel (plane_sel),
        .mode      (mode),
        .start_idx (start_idx),
        .count     (count),
        .plane_bus (plane_bus),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .done      (done)
    );

    typedef struct packed {
        logic [WIN*PIX_W-1:0] data;
        logic [IDX_W-1:0]     idx;
        logic                 last;
    } beat_t;

    beat_t exp_q[$];
    int    checks    = 0;
    int    errors    = 0;
    int    cyc       = 0;
    int    done_seen = 0;
    int    exp_done  = 0;
    int    done_ref  = -1;
    bit    toggle    = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] pix(int p, int r, int c);
        logic [5:0] hi;
        hi = {p[1:0], r[3:0]};
        return {2'b00, hi} ^ 8'(c);
    endfunction

    function automatic logic [WIN*PIX_W-1:0] vector(int p, int idx, int col);
        logic [WIN*PIX_W-1:0] v;
        for (int k = 0; k < WIN; k++) begin
            v[k*PIX_W +: PIX_W] = (col != 0) ? pix(p, k, idx) : pix(p, idx, k);
        end
        return v;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat actual_index=%0d required=no_beat", out_index);
                end else begin
                    if (out_data !== exp_q[0].data || out_index !== exp_q[0].idx ||
                        out_last !== exp_q[0].last) begin
                        errors++;
                        $display("FAIL beat actual=%0h/%0d/%0b required=%0h/%0d/%0b",
                                 out_data, out_index, out_last,
                                 exp_q[0].data, exp_q[0].idx, exp_q[0].last);
                    end
                    if (out_ready) begin
                        if (exp_q[0].last) done_ref = cyc + 1;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (done) begin
                done_seen++;
                checks++;
                if (cyc != done_ref) begin
                    errors++;
                    $display("FAIL done_timing actual_cycle=%0d required_cycle=%0d", cyc, done_ref);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (toggle) out_ready = ~out_ready;
        end
    end

    task automatic issue(int p, int idx, int cnt, int md, bit accepted);
        beat_t b;
        int    ci;
        @(posedge clock);
        #1;
        start     = 1'b1;
        plane_sel = PSEL_W'(p);
        start_idx = IDX_W'(idx);
        count     = CNT_W'(cnt);
        mode      = md[0];
        ci        = (idx >= WIN) ? 0 : idx;
`ifndef WINDOW_COLUMN_MODE_EN
        md = 0;
`endif
        if (accepted) begin
            if (cnt == 0) done_ref = cyc + 1;
            for (int i = 0; i < cnt; i++) begin
                b.idx  = IDX_W'((ci + i) % WIN);
                b.data = vector(p, (ci + i) % WIN, md);
                b.last = (i == cnt - 1);
                exp_q.push_back(b);
            end
            exp_done++;
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        if (accepted && cnt > 0) chk("first_beat_latency", 128'(out_valid), 128'(1));
        if (accepted && cnt == 0) chk("zero_count_busy", 128'(busy), 128'(0));
    endtask

    task automatic wait_done(string name);
        int n;
        n = 0;
        while (done_seen < exp_done && n < 200) begin
            @(posedge clock);
            n++;
        end
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (done_seen != exp_done) begin
            errors++;
            $display("FAIL %s_done_count actual=%0d required=%0d", name, done_seen, exp_done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_beats_left actual=%0d required=0", name, exp_q.size());
        end
        chk({name, "_idle_busy"}, 128'(busy), 128'(0));
    endtask

    task automatic chk_reset_state(string name);
        chk({name, "_busy"}, 128'(busy), 128'(0));
        chk({name, "_valid"}, 128'(out_valid), 128'(0));
        chk({name, "_data"}, 128'(out_data), 128'(0));
        chk({name, "_index"}, 128'(out_index), 128'(0));
        chk({name, "_last"}, 128'(out_last), 128'(0));
        chk({name, "_done"}, 128'(done), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int p = 0; p < NP; p++)
            for (int r = 0; r < WIN; r++)
                for (int c = 0; c < WIN; c++)
                    plane_bus[((p * WIN + r) * WIN + c) * PIX_W +: PIX_W] = pix(p, r, c);
        reset     = 1'b1;
        start     = 1'b0;
        plane_sel = '0;
        mode      = 1'b0;
        start_idx = '0;
        count     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk_reset_state("por");
        reset = 1'b0;

        // Reset in the middle of a 10-beat command aborts it.
        issue(1, 0, 10, 0, 1);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        exp_done--;
        @(posedge clock);
        #1;
        chk_reset_state("mid_reset");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_reset_state("post_reset");
        chk("post_reset_no_done", 128'(done_seen), 128'(exp_done));

        // Plane 0 rows 2,3,4.
        issue(0, 2, 3, 0, 1);
        wait_done("row_basic");

        // Plane 2 rows 13,14,0,1 across the wrap.
        issue(2, 13, 4, 0, 1);
        wait_done("row_wrap");

        // Stalls every other cycle.
        toggle = 1;
        issue(1, 6, 5, 0, 1);
        wait_done("stall");
        toggle    = 0;
        out_ready = 1'b1;

        // Zero count, then a start ignored while busy.
        issue(3, 4, 0, 0, 1);
        wait_done("zero_count");
        issue(0, 7, 3, 0, 1);
        issue(2, 1, 5, 0, 0);
        wait_done("busy_ignore");

        // Out-of-range index clamps to 0; full-window run hits WIN beats.
        issue(1, 15, 1, 0, 1);
        wait_done("idx_clamp");
        issue(3, 9, 15, 0, 1);
        wait_done("full_run");

`ifdef WINDOW_COLUMN_MODE_EN
        issue(3, 5, 2, 1, 1);
        wait_done("column");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
